timer_device: RTL and testbench

//  Memory-mapped timer peripheral on the CPU bridge. Responds to word/half/byte stores and loads issued by the memory stage.
//  It decrements a counter from a preset value and raises an interrupt request back to the CPU.

---
 rtl/timer_device.sv | 160 ++++++++++++++++
 tb/tb_timer_device.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a maskable interrupt request.
// Ports: clk, reset (async, active-low), Addr/WE/ByteEn/DataIn store port, DataOut combinational read, IRQ out.
// Store latency: registers update on the edge that samples WE; DataOut is combinational, so reads have zero latency.
// Build option: define TIMER_STATE_READBACK_EN to expose FSM state in CTRL[6:4].
module timer_device #(
   parameter int               CNT_W        = 32,
   parameter logic [CNT_W-1:0] PRESET_RESET = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [3:0]  ByteEn,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t           state;
   state_t           nextState;

   logic             ctrlEn;
   logic [1:0]       ctrlMode;
   logic             ctrlIm;
   logic [CNT_W-1:0] preset;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] countNext;
   logic             hwClrEn;

   logic             ctrlWr;
   logic             presetWr;
   logic [31:0]      presetExt;
   logic [31:0]      countExt;
   logic [31:0]      presetMerged;

   // A CTRL store with no byte enabled is not a write at all; any enabled
   // lane counts as a CTRL write (and releases a one-shot INT), even if it
   // does not touch byte 0 where the control bits live.
   assign ctrlWr   = WE && (Addr == 2'd0) && (|ByteEn);
   assign presetWr = WE && (Addr == 2'd1) && (|ByteEn);

   assign presetExt = 32'(preset);
   assign countExt  = 32'(count);

   always_comb begin
      presetMerged = presetExt;
      for (int i = 0; i < 4; i++) begin
         if (ByteEn[i]) begin
            presetMerged[8*i +: 8] = DataIn[8*i +: 8];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // FSM next-state and counter datapath
   always_comb begin
      nextState = state;
      countNext = count;
      hwClrEn   = 1'b0;
      case (state)
         IDLE: begin
            if (ctrlEn) begin
               nextState = LOAD;
            end
         end
         LOAD: begin
            if (!ctrlEn) begin
               nextState = IDLE;
            end else begin
               countNext = preset;
               nextState = CNT;
            end
         end
         CNT: begin
            if (!ctrlEn) begin
               nextState = IDLE;
            end else if (count <= CNT_W'(1)) begin
               countNext = '0;
               nextState = INT;
               // One-shot (and the undefined 1x modes) disarm on expiry.
               if (ctrlMode != 2'b01) begin
                  hwClrEn = 1'b1;
               end
            end else begin
               countNext = count - CNT_W'(1);
            end
         end
         INT: begin
            // A CTRL write always returns to IDLE, even when it coincides
            // with the auto-reload transition.
            if (ctrlWr) begin
               nextState = IDLE;
            end else if (ctrlMode == 2'b01) begin
               nextState = LOAD;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Register file; CPU writes take priority over the hardware Enable clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrlEn   <= 1'b0;
         ctrlMode <= 2'b00;
         ctrlIm   <= 1'b0;
         preset   <= PRESET_RESET;
         count    <= '0;
      end else begin
         count <= countNext;
         if (ctrlWr && ByteEn[0]) begin
            ctrlEn   <= DataIn[0];
            ctrlMode <= DataIn[2:1];
            ctrlIm   <= DataIn[3];
         end else if (hwClrEn) begin
            ctrlEn <= 1'b0;
         end
         if (presetWr) begin
            preset <= presetMerged[CNT_W-1:0];
         end
      end
   end

   // Decoded from registered state only, so it cannot glitch.
   assign IRQ = (state == INT) && ctrlIm;

   always_comb begin
      DataOut = '0;
      case (Addr)
         2'd0: begin
            DataOut[3:0] = {ctrlIm, ctrlMode, ctrlEn};
`ifdef TIMER_STATE_READBACK_EN
            DataOut[5:4] = state;
            DataOut[6]   = (state == INT);
`else
            DataOut[6:4] = 3'b000;
`endif
         end
         2'd1:    DataOut = presetExt;
         2'd2:    DataOut = countExt;
         default: DataOut = '0;
      endcase
   end

endmodule

// File: tb/tb_timer_device.sv
module tb_timer_device;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  Addr;
   logic        WE;
   logic [3:0]  ByteEn;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        IRQ;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] PRST = 32'h1234_5678;

   always #5 clk = ~clk;

   timer_device #(.CNT_W(32), .PRESET_RESET(PRST)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .ByteEn(ByteEn),
      .DataIn(DataIn), .DataOut(DataOut), .IRQ(IRQ)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Store taking effect on the next rising edge.
   task automatic store(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
      Addr = a; ByteEn = be; DataIn = d; WE = 1'b1;
      @(posedge clk);
      #1;
      WE = 1'b0; ByteEn = 4'h0; DataIn = 32'h0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      Addr = a;
      #1;
      v = DataOut;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      reset = 1'b0; WE = 1'b0; Addr = 2'd0; ByteEn = 4'h0; DataIn = 32'h0;
      #22;
      reset = 1'b1;
      step(1);
      rd(2'd0, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h expected %h", v, 32'h0); end
      rd(2'd1, v);
      checks++; if (v !== PRST) begin failures++; $display("FAIL reset_preset: got %h expected %h", v, PRST); end
      rd(2'd2, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_count: got %h expected %h", v, 32'h0); end
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
   endtask

   task automatic test_one_shot;
      logic [31:0] v;
      logic        e;
      store(2'd1, 4'hF, 32'd5);
      store(2'd0, 4'hF, 32'h9);
      for (int k = 1; k <= 7; k++) begin
         step(1);
         e = (k == 7);
         checks++; if (IRQ !== e) begin failures++; $display("FAIL oneshot_irq edge %0d: got %b expected %b", k, IRQ, e); end
      end
      step(3);
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL oneshot_irq_held: got %b expected 1", IRQ); end
      rd(2'd0, v);
      checks++; if (v !== 32'h8) begin failures++; $display("FAIL oneshot_ctrl: got %h expected %h", v, 32'h8); end
      rd(2'd2, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL oneshot_count: got %h expected %h", v, 32'h0); end
      store(2'd0, 4'hF, 32'h0);
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL oneshot_irq_clear: got %b expected 0", IRQ); end
   endtask

   task automatic test_auto_reload;
      logic [31:0] v;
      logic [31:0] ec;
      logic        e;
      int          ph;
      store(2'd1, 4'hF, 32'd3);
      store(2'd0, 4'hF, 32'hB);
      for (int k = 1; k <= 21; k++) begin
         step(1);
         e = (k >= 5) && (((k - 5) % 5) == 0);
         checks++; if (IRQ !== e) begin failures++; $display("FAIL reload_irq edge %0d: got %b expected %b", k, IRQ, e); end
         if (k >= 2) begin
            ph = (k - 2) % 5;
            ec = (ph < 3) ? 32'(3 - ph) : 32'd0;
            rd(2'd2, v);
            checks++; if (v !== ec) begin failures++; $display("FAIL reload_count edge %0d: got %0d expected %0d", k, v, ec); end
         end
      end
      store(2'd0, 4'hF, 32'h0);
      step(2);
   endtask

   task automatic test_pause;
      logic [31:0] v;
      store(2'd1, 4'hF, 32'd10);
      store(2'd0, 4'hF, 32'h1);
      step(5);
      rd(2'd2, v);
      checks++; if (v !== 32'd7) begin failures++; $display("FAIL pause_pre: got %0d expected 7", v); end
      // This edge takes COUNT to 6 and clears Enable together.
      store(2'd0, 4'hF, 32'h0);
      for (int k = 0; k < 20; k++) begin
         step(1);
         rd(2'd2, v);
         checks++; if (v !== 32'd6) begin failures++; $display("FAIL pause_hold cycle %0d: got %0d expected 6", k, v); end
      end
      store(2'd0, 4'hF, 32'h1);
      step(1);
      rd(2'd2, v);
      checks++; if (v !== 32'd6) begin failures++; $display("FAIL pause_load_edge: got %0d expected 6", v); end
      step(1);
      rd(2'd2, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL pause_reload: got %0d expected 10", v); end
      store(2'd0, 4'hF, 32'h0);
      step(1);
   endtask

   task automatic test_byte_lanes;
      logic [31:0] v;
      store(2'd1, 4'hF, 32'h0);
      store(2'd1, 4'b0010, 32'h0000AB00);
      rd(2'd1, v);
      checks++; if (v !== 32'h0000AB00) begin failures++; $display("FAIL lane1_preset: got %h expected %h", v, 32'h0000AB00); end
      store(2'd1, 4'b1000, 32'h5A00_0000);
      rd(2'd1, v);
      checks++; if (v !== 32'h5A00AB00) begin failures++; $display("FAIL lane3_preset: got %h expected %h", v, 32'h5A00AB00); end
      store(2'd0, 4'hF, 32'h8);
      store(2'd0, 4'b0000, 32'hF);
      rd(2'd0, v);
      checks++; if (v !== 32'h8) begin failures++; $display("FAIL ctrl_no_lanes: got %h expected %h", v, 32'h8); end
      store(2'd0, 4'b1110, 32'hFFFF_FF07);
      rd(2'd0, v);
      checks++; if (v !== 32'h8) begin failures++; $display("FAIL ctrl_upper_lanes: got %h expected %h", v, 32'h8); end
      store(2'd2, 4'hF, 32'h55);
      rd(2'd2, v);
      checks++; if (v !== 32'd9) begin failures++; $display("FAIL count_readonly: got %0d expected 9", v); end
      store(2'd3, 4'hF, 32'hDEAD_BEEF);
      rd(2'd3, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL addr3_read: got %h expected %h", v, 32'h0); end
      rd(2'd1, v);
      checks++; if (v !== 32'h5A00AB00) begin failures++; $display("FAIL addr3_write_ignored: got %h expected %h", v, 32'h5A00AB00); end
      store(2'd0, 4'hF, 32'h0);
   endtask

   task automatic test_int_write_priority;
      logic [31:0] v;
      store(2'd1, 4'hF, 32'd1);
      store(2'd0, 4'hF, 32'hB);
      step(3);
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL prio_irq_e3: got %b expected 1", IRQ); end
      // CTRL write in the auto-reload INT cycle must send the FSM to IDLE.
      store(2'd0, 4'hF, 32'hB);
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL prio_irq_e4: got %b expected 0", IRQ); end
      step(1);
      rd(2'd2, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL prio_count_e5: got %0d expected 0", v); end
      step(1);
      rd(2'd2, v);
      checks++; if (v !== 32'd1) begin failures++; $display("FAIL prio_count_e6: got %0d expected 1", v); end
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL prio_irq_e6: got %b expected 0", IRQ); end
      step(1);
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL prio_irq_e7: got %b expected 1", IRQ); end
      store(2'd0, 4'hF, 32'h0);
      step(1);
   endtask

   task automatic test_corners;
      logic [31:0] v;
      logic        e;
      store(2'd1, 4'hF, 32'd0);
      store(2'd0, 4'hF, 32'h9);
      for (int k = 1; k <= 3; k++) begin
         step(1);
         e = (k == 3);
         checks++; if (IRQ !== e) begin failures++; $display("FAIL zero_preset_irq edge %0d: got %b expected %b", k, IRQ, e); end
      end
      store(2'd0, 4'hF, 32'h0);
      // Reset in the middle of a count.
      store(2'd1, 4'hF, 32'd100);
      store(2'd0, 4'hF, 32'h9);
      step(5);
      rd(2'd2, v);
      checks++; if (v !== 32'd97) begin failures++; $display("FAIL midcount_pre: got %0d expected 97", v); end
      reset = 1'b0;
      #1;
      checks++; if (DataOut !== 32'h0) begin failures++; $display("FAIL midcount_reset_count: got %0d expected 0", DataOut); end
      rd(2'd1, v);
      checks++; if (v !== PRST) begin failures++; $display("FAIL midcount_reset_preset: got %h expected %h", v, PRST); end
      reset = 1'b1;
      step(1);
      // Reset while IRQ is high.
      store(2'd1, 4'hF, 32'd2);
      store(2'd0, 4'hF, 32'h9);
      step(4);
      checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL irq_before_reset: got %b expected 1", IRQ); end
      reset = 1'b0;
      #1;
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL irq_async_reset: got %b expected 0", IRQ); end
      rd(2'd0, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL ctrl_async_reset: got %h expected %h", v, 32'h0); end
      reset = 1'b1;
      step(1);
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_pause();
      test_byte_lanes();
      test_int_write_priority();
      test_corners();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
